// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file access arbiter.
package regfile_arb_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  write;
        logic                  imm;
        logic [DEF_ADDR_W-1:0] addrA;
        logic [DEF_ADDR_W-1:0] addrB;
        logic [DEF_DATA_W-1:0] immValue;
        logic [DEF_DATA_W-1:0] writeData;
    } rf_req_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_access_arbiter_rr_arbiter.sv
// Combinational winner select for the register-file arbiter.
// REGFILE_ARB_FIXED_PRIORITY_EN selects fixed priority (lowest index wins) instead of round-robin.
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic               any_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     winner_o,
    output logic [IDW-1:0]     next_ptr_o
);

    logic found;

    assign any_o = |req_valid_i;

`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        grant_o    = '0;
        winner_o   = '0;
        found      = 1'b0;
        next_ptr_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[i]) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                winner_o   = IDW'(i);
            end
        end
    end
`else
    // First pass covers pointer..top, second pass wraps to the indices below the pointer.
    always_comb begin
        grant_o    = '0;
        winner_o   = '0;
        found      = 1'b0;
        next_ptr_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (i >= int'(ptr_i)) && req_valid_i[i]) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                winner_o   = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[i]) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                winner_o   = IDW'(i);
            end
        end
        next_ptr_o = (int'(winner_o) == NUM_REQ - 1) ? '0 : winner_o + IDW'(1);
    end
`endif

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares one registered-read register file between NUM_REQ requesters: grant, issue, capture.
// Build option REGFILE_ARB_FIXED_PRIORITY_EN (in rr_arbiter) switches to fixed priority.
module regfile_access_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    parameter int  ADDR_W  = DEF_ADDR_W,
    parameter int  DATA_W  = DEF_DATA_W,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic [NUM_REQ-1:0]        reqValid,
    output logic [NUM_REQ-1:0]        reqReady,
    input  logic [NUM_REQ-1:0]        reqWrite,
    input  logic [NUM_REQ-1:0]        reqImm,
    input  logic [NUM_REQ*ADDR_W-1:0] reqAddrA,
    input  logic [NUM_REQ*ADDR_W-1:0] reqAddrB,
    input  logic [NUM_REQ*DATA_W-1:0] reqImmValue,
    input  logic [NUM_REQ*DATA_W-1:0] reqWriteData,
    output logic                      rspValid,
    output logic [IDW-1:0]            rspId,
    output logic [DATA_W-1:0]         rspDataA,
    output logic [DATA_W-1:0]         rspDataB,
    output logic                      rfRegWrite,
    output logic                      rfImmediate,
    output logic [ADDR_W-1:0]         rfReadRegister1,
    output logic [ADDR_W-1:0]         rfReadRegister2,
    output logic [DATA_W-1:0]         rfLtValue,
    output logic [DATA_W-1:0]         rfWriteData,
    input  logic [DATA_W-1:0]         rfReadData1,
    input  logic [DATA_W-1:0]         rfReadData2
);

    arb_state_t         state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    rf_req_t            req_q, req_d;
    rf_req_t            sel_req;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_a_q, rsp_a_d;
    logic [DATA_W-1:0]  rsp_b_q, rsp_b_d;

    logic               any_req;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req_valid_i (reqValid),
        .ptr_i       (ptr_q),
        .any_o       (any_req),
        .grant_o     (grant),
        .winner_o    (winner),
        .next_ptr_o  (next_ptr)
    );

    // One-hot grant makes the OR-mux equivalent to selecting the winner's fields.
    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_req.write     = reqWrite[i];
                sel_req.imm       = reqImm[i];
                sel_req.addrA     = reqAddrA[i*ADDR_W +: ADDR_W];
                sel_req.addrB     = reqAddrB[i*ADDR_W +: ADDR_W];
                sel_req.immValue  = reqImmValue[i*DATA_W +: DATA_W];
                sel_req.writeData = reqWriteData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        req_d           = req_q;
        id_d            = id_q;
        rsp_valid_d     = 1'b0;
        rsp_id_d        = rsp_id_q;
        rsp_a_d         = rsp_a_q;
        rsp_b_d         = rsp_b_q;
        reqReady        = '0;
        rfRegWrite      = 1'b0;
        rfImmediate     = 1'b0;
        rfReadRegister1 = '0;
        rfReadRegister2 = '0;
        rfLtValue       = '0;
        rfWriteData     = '0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    // State sits at IDLE during reset, so mask the grant pulse there.
                    reqReady = grant & {NUM_REQ{resetN}};
                    req_d    = sel_req;
                    id_d     = winner;
                    ptr_d    = next_ptr;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                rfRegWrite      = req_q.write;
                rfImmediate     = req_q.imm;
                rfReadRegister1 = req_q.addrA;
                rfReadRegister2 = req_q.addrB;
                rfLtValue       = req_q.immValue;
                rfWriteData     = req_q.writeData;
                state_d         = CAPTURE;
            end
            CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_a_d     = rfReadData1;
                rsp_b_d     = rfReadData2;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            req_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            req_q       <= req_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
        end
    end

    assign rspValid = rsp_valid_q;
    assign rspId    = rsp_id_q;
    assign rspDataA = rsp_a_q;
    assign rspDataB = rsp_b_q;

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Shares the single 8-entry x 8-bit register file between NUM_REQ requesters, e.g. the core pipeline and a debug/load unit.
- Accepts one request per grant and drives the register-file control inputs: regWrite, immediate, readRegister1/2, ltValue, writeData.
- Waits out the register file's one-cycle registered read latency, then returns the read data to the granted requester, tagged with its ID.
- Sits between the requesters and the register file.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_W, 3, register address width
DATA_W, 8, register data width

Ports:
clock  in  1  system clock, rising edge
resetN  in  1  asynchronous, active-low reset
reqValid  in  NUM_REQ  per-requester request valid
reqReady  out  NUM_REQ  one-cycle grant/accept pulse, one-hot
reqWrite  in  NUM_REQ  request writes reqWriteData to reqAddrA
reqImm  in  NUM_REQ  operand B is the request's reqImmValue, not a register
reqAddrA  in  NUM_REQ*ADDR_W  per-requester address A (read and write address)
reqAddrB  in  NUM_REQ*ADDR_W  per-requester address B
reqImmValue  in  NUM_REQ*DATA_W  per-requester immediate
reqWriteData  in  NUM_REQ*DATA_W  per-requester write data
rspValid  out  1  response valid, one cycle
rspId  out  clog2(NUM_REQ)  requester index of the response
rspDataA  out  DATA_W  read data 1
rspDataB  out  DATA_W  read data 2, or the immediate
rfRegWrite  out  1  to register file regWrite
rfImmediate  out  1  to register file immediate
rfReadRegister1  out  ADDR_W  to register file readRegister1
rfReadRegister2  out  ADDR_W  to register file readRegister2
rfLtValue  out  DATA_W  to register file ltValue
rfWriteData  out  DATA_W  to register file writeData
rfReadData1  in  DATA_W  from register file readData1
rfReadData2  in  DATA_W  from register file readData2

Behaviour:
- Reset (resetN low, asynchronous):
  - state=IDLE; round-robin pointer=0.
  - All outputs 0: reqReady, rspValid, rspId, rspData*, and all rf* signals.
  - Any in-flight operation is dropped; no rspValid follows after reset.
- Every request is a single operation that is allowed to both read and write.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - If any reqValid, choose a winner by round-robin, searching upward from the pointer and wrapping at NUM_REQ-1 -> 0.
  - Assert reqReady[winner] combinationally in that cycle.
  - Latch the winner's fields and ID; go to ISSUE.
  - Pointer <= winner+1, modulo NUM_REQ.
  - If no reqValid, stay in IDLE.
- ISSUE (1 cycle):
  - Drive rf* from the latched request:
    - rfRegWrite=write
    - rfImmediate=imm
    - rfReadRegister1=addrA
    - rfReadRegister2=addrB
    - rfLtValue=immValue
    - rfWriteData=writeData
  - Go to CAPTURE.
  - rf* are 0 in every state other than ISSUE.
- CAPTURE (1 cycle):
  - Register rfReadData1/2 into rspDataA/B and assert rspValid with the latched rspId on the following cycle.
  - Go to IDLE.
  - For a write request, rspDataA is the pre-write value (read-before-write).
- Latency and handshake:
  - Latency from grant to rspValid is 3 cycles; throughput is 1 operation per 3 cycles.
  - reqReady is never asserted outside IDLE.
  - Requesters hold reqValid and the request fields until they see reqReady.
  - rspData* hold their value until the next response.
- A requester dropping reqValid before its grant is legal; it is simply not selected.
- Simultaneous requests: exactly one winner; losers wait, with no starvation. Under continuous contention each requester is granted at least once every NUM_REQ grants.

Optional Feature:
- Macro: REGFILE_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins; the pointer is unused and held at 0.
- Undefined: round-robin as above.

Decomposition:
- Package regfile_arb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - Enum arb_state_t {IDLE, ISSUE, CAPTURE}.
  - Packed struct rf_req_t {write, imm, addrA, addrB, immValue, writeData}.
- One sub-module: rr_arbiter.
  - Combinational winner select from reqValid plus the pointer.
  - Contains the REGFILE_ARB_FIXED_PRIORITY_EN switch.

Test Plan:
- Reset, then a single write: req0 write reg3=0x5A.
  - reqReady[0] pulses; in ISSUE, rfRegWrite=1 and rfReadRegister1=3.
  - 3 cycles after grant: rspValid=1, rspId=0.
  - A following read of reg3 from req1 returns rspDataA=0x5A.
- Immediate read: req1 reads addrA=3, imm=1, immValue=0x11.
  - rfImmediate=1 in ISSUE; response rspDataA=0x5A, rspDataB=0x11.
- Contention: both requesters hold reqValid for 6 grants.
  - Grants alternate 0,1,0,1,0,1.
  - With REGFILE_ARB_FIXED_PRIORITY_EN defined: all 6 grants go to 0.
- Back-to-back: req0 keeps reqValid high.
  - Grants occur exactly every 3 cycles; reqReady is never high in ISSUE or CAPTURE.
- Reset mid-operation: assert resetN low during ISSUE.
  - All outputs are 0 immediately; no rspValid afterward; the next grant goes to req0.
- Read-before-write: req0 writes reg2=0x77 while reg2 holds 0x10.
  - That response gives rspDataA=0x10; a subsequent read returns 0x77.
